// File: rtl/ray_sphere_multi_worker_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : ray_sphere_multi_worker_pkg                                    |
// | Brief    : Shared types and exact arithmetic widths for the ray/sphere    |
// |            worker and its discriminant pipeline.                          |
// | Revision : 1.0 - initial release                                          |
// ---------------------------------------------------------------------------
package ray_sphere_multi_worker_pkg;

  typedef logic [11:0] color_t;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
    logic [9:0]         r;
    color_t             color;
  } sphere_t;

  // Widths sized so that no intermediate ever truncates.
  localparam int A_B      = 24;
  localparam int HB_B     = 29;
  localparam int CC_B     = 33;
  localparam int DISC_B   = 59;
  localparam int DISC_LAT = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_DRAIN  = 3'd2,
    S_SQRT   = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  // Index width that stays legal for a count of one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ray_sphere_multi_worker_disc_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : ray_disc_unit                                                  |
// | Brief    : Three-stage half-b ray/sphere discriminant pipeline:           |
// |            products, sums, then disc = hb*hb - a*cc and the hit flag.     |
// | Revision : 1.0 - initial release                                          |
// ---------------------------------------------------------------------------
module ray_disc_unit
  import ray_sphere_multi_worker_pkg::*;
#(
  parameter int FOCAL = 320,
  parameter int IDX_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [IDX_W-1:0]         in_idx,
  input  logic signed [11:0]       in_px,
  input  logic signed [11:0]       in_py,
  input  sphere_t                  in_sphere,
  output logic                     out_valid,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_hit,
  output logic signed [HB_B-1:0]   out_hb,
  output logic signed [DISC_B-1:0] out_disc
);

  localparam logic signed [27:0] FOC    = 28'(FOCAL);
  localparam logic [A_B-1:0]     FOC_SQ = A_B'(FOCAL * FOCAL);

  logic [1:0]       r_v1_v2;
  logic [IDX_W-1:0] r_idx1, r_idx2;

  logic [A_B-1:0]          r1_pxx, r1_pyy;
  logic signed [27:0]      r1_pcx, r1_pcy, r1_fcz;
  logic [31:0]             r1_cxx, r1_cyy, r1_czz;
  logic [19:0]             r1_rr;
  logic [A_B-1:0]          r2_a;
  logic signed [HB_B-1:0]  r2_hb;
  logic signed [CC_B-1:0]  r2_cc;
  logic signed [DISC_B-1:0] w_disc;

  // a is non-negative, so it joins the signed product with a zero sign bit.
  assign w_disc = DISC_B'(r2_hb) * DISC_B'(r2_hb)
                - DISC_B'($signed({1'b0, r2_a})) * DISC_B'(r2_cc);

  // Valid and index travel alongside the data through all three stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1_v2   <= 2'b00;
      out_valid <= 1'b0;
      r_idx1    <= '0;
      r_idx2    <= '0;
      out_idx   <= '0;
    end else begin
      r_v1_v2   <= {r_v1_v2[0], in_valid};
      out_valid <= r_v1_v2[1];
      r_idx1    <= in_idx;
      r_idx2    <= r_idx1;
      out_idx   <= r_idx2;
    end
  end

  // Arithmetic stages; operands are widened before multiplying.
  always_ff @(posedge clk) begin
    r1_pxx <= A_B'(in_px) * A_B'(in_px);
    r1_pyy <= A_B'(in_py) * A_B'(in_py);
    r1_pcx <= 28'(in_px) * 28'($signed(in_sphere.x));
    r1_pcy <= 28'(in_py) * 28'($signed(in_sphere.y));
    r1_fcz <= FOC * 28'($signed(in_sphere.z));
    r1_cxx <= 32'($signed(in_sphere.x)) * 32'($signed(in_sphere.x));
    r1_cyy <= 32'($signed(in_sphere.y)) * 32'($signed(in_sphere.y));
    r1_czz <= 32'($signed(in_sphere.z)) * 32'($signed(in_sphere.z));
    r1_rr  <= 20'(in_sphere.r) * 20'(in_sphere.r);

    r2_a   <= r1_pxx + r1_pyy + FOC_SQ;
    r2_hb  <= HB_B'(r1_pcx) + HB_B'(r1_pcy) + HB_B'(r1_fcz);
    r2_cc  <= CC_B'(r1_cxx) + CC_B'(r1_cyy) + CC_B'(r1_czz) - CC_B'(r1_rr);

    out_hb   <= r2_hb;
    out_disc <= w_disc;
    out_hit  <= !r2_hb[HB_B-1] && (r2_hb != '0) && !w_disc[DISC_B-1];
  end

endmodule
`default_nettype wire

// File: rtl/ray_sphere_multi_worker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : ray_sphere_multi_worker                                        |
// | Brief    : Shades JOBS strided pixels of one row against N_SPHERES        |
// |            spheres and writes one colour per pixel into buf_o.            |
// |            Build macro RT_WORKER_DEPTH_EN selects nearest-depth winner    |
// |            (serial isqrt per hit); default is lowest-index winner.        |
// | Revision : 1.0 - initial release                                          |
// ---------------------------------------------------------------------------
module ray_sphere_multi_worker
  import ray_sphere_multi_worker_pkg::*;
#(
  parameter int     N_SPHERES = 4,
  parameter int     JOBS      = 8,
  parameter int     N_WORKERS = 4,
  parameter int     FOCAL     = 320,
  parameter color_t BG_COLOR  = 12'h000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic signed [11:0]            pixel_start_x,
  input  logic signed [11:0]            pixel_y,
  input  sphere_t [N_SPHERES-1:0]       sphere_i,
  input  logic [N_SPHERES-1:0]          sphere_en_i,
  output logic                          busy,
  output logic                          done,
  output color_t [JOBS-1:0]             buf_o
);

  localparam int            IW       = idx_width(N_SPHERES);
  localparam int            JW       = idx_width(JOBS);
  localparam logic [IW-1:0] K_LAST   = IW'(N_SPHERES - 1);
  localparam logic [JW-1:0] J_LAST   = JW'(JOBS - 1);
  localparam logic [3:0]    CNT_LAST = 4'(DISC_LAT - 1);

  state_t                  r_state, w_next;
  logic                    w_issue;
  logic [JW-1:0]           r_job;
  logic [IW-1:0]           r_k;
  logic [3:0]              r_cnt;
  logic signed [11:0]      r_px, r_py;
  sphere_t [N_SPHERES-1:0] r_sph;
  logic [N_SPHERES-1:0]    r_en;
  logic                    r_found;
  color_t                  r_win;

  logic                     w_out_valid, w_out_hit;
  logic [IW-1:0]            w_out_idx;
  logic signed [HB_B-1:0]   w_out_hb;
  logic signed [DISC_B-1:0] w_out_disc;

  ray_disc_unit #(.FOCAL(FOCAL), .IDX_W(IW)) u_disc (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_issue),
    .in_idx    (r_k),
    .in_px     (r_px),
    .in_py     (r_py),
    .in_sphere (r_sph[r_k]),
    .out_valid (w_out_valid),
    .out_idx   (w_out_idx),
    .out_hit   (w_out_hit),
    .out_hb    (w_out_hb),
    .out_disc  (w_out_disc)
  );

`ifdef RT_WORKER_DEPTH_EN
  localparam logic [IW:0] SQ_END = (IW + 1)'(N_SPHERES);

  logic                     r_hit  [N_SPHERES];
  logic signed [HB_B-1:0]   r_hb   [N_SPHERES];
  logic signed [DISC_B-1:0] r_disc [N_SPHERES];
  logic [IW:0]              r_sq_k;
  logic                     r_sq_run;
  logic [4:0]               r_sq_bit;
  logic [32:0]              r_rem;
  logic [29:0]              r_root;
  logic [59:0]              r_op;
  logic signed [HB_B+1:0]   r_best;
  logic [IW-1:0]            w_sq_idx;
  logic [32:0]              w_rem_sh, w_trial, w_rem_nx;
  logic                     w_ge;
  logic [29:0]              w_root_nx;
  logic signed [HB_B+1:0]   w_key;

  // One restoring square-root digit per cycle; key is hb - isqrt(disc).
  assign w_sq_idx  = r_sq_k[IW-1:0];
  assign w_rem_sh  = {r_rem[30:0], r_op[59:58]};
  assign w_trial   = {1'b0, r_root, 2'b01};
  assign w_ge      = (w_rem_sh >= w_trial);
  assign w_rem_nx  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
  assign w_root_nx = {r_root[28:0], w_ge};
  assign w_key     = (HB_B + 2)'(r_hb[w_sq_idx]) - (HB_B + 2)'($signed({1'b0, w_root_nx}));

  // Keep every sphere's result for the serial depth pass.
  always_ff @(posedge clk) begin
    if (w_out_valid) begin
      r_hit[w_out_idx]  <= w_out_hit && r_en[w_out_idx];
      r_hb[w_out_idx]   <= w_out_hb;
      r_disc[w_out_idx] <= w_out_disc;
    end
  end

  // Walk the spheres in index order, rooting each hit; strict < keeps ties low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sq_k <= '0; r_sq_run <= 1'b0; r_sq_bit <= '0;
      r_rem <= '0; r_root <= '0; r_op <= '0;
      r_best <= '0; r_found <= 1'b0; r_win <= '0;
    end else if (r_state == S_DRAIN) begin
      r_sq_k   <= '0;
      r_sq_run <= 1'b0;
      r_found  <= 1'b0;
    end else if (r_state == S_SQRT) begin
      if (r_sq_run) begin
        r_rem    <= w_rem_nx;
        r_root   <= w_root_nx;
        r_op     <= {r_op[57:0], 2'b00};
        r_sq_bit <= r_sq_bit + 5'd1;
        if (r_sq_bit == 5'd29) begin
          r_sq_run <= 1'b0;
          r_sq_k   <= r_sq_k + 1'b1;
          if (!r_found || (w_key < r_best)) begin
            r_found <= 1'b1;
            r_best  <= w_key;
            r_win   <= r_sph[w_sq_idx].color;
          end
        end
      end else if (r_sq_k != SQ_END) begin
        if (r_hit[w_sq_idx]) begin
          r_op     <= {1'b0, r_disc[w_sq_idx]};
          r_rem    <= '0;
          r_root   <= '0;
          r_sq_bit <= '0;
          r_sq_run <= 1'b1;
        end else begin
          r_sq_k <= r_sq_k + 1'b1;
        end
      end
    end
  end
`else
  // Depth outputs are only consumed when depth ordering is built in.
  logic w_unused_depth;
  assign w_unused_depth = ^{w_out_hb, w_out_disc};

  // Results arrive in index order, so the first hit is the lowest index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_found <= 1'b0;
      r_win   <= '0;
    end else if (r_state == S_COMMIT || r_state == S_IDLE) begin
      r_found <= 1'b0;
    end else if (w_out_valid && w_out_hit && r_en[w_out_idx] && !r_found) begin
      r_found <= 1'b1;
      r_win   <= r_sph[w_out_idx].color;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and the disc-unit issue strobe.
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_next = S_ISSUE;
      S_ISSUE: begin
        w_issue = 1'b1;
        if (r_k == K_LAST) w_next = S_DRAIN;
      end
`ifdef RT_WORKER_DEPTH_EN
      S_DRAIN:  if (r_cnt == CNT_LAST) w_next = S_SQRT;
      S_SQRT:   if (!r_sq_run && (r_sq_k == SQ_END)) w_next = S_COMMIT;
`else
      S_DRAIN:  if (r_cnt == CNT_LAST) w_next = S_COMMIT;
`endif
      S_COMMIT: w_next = (r_job == J_LAST) ? S_IDLE : S_ISSUE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Job bookkeeping, input latching, buffer writes and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0; done <= 1'b0; buf_o <= '0;
      r_job <= '0; r_k <= '0; r_cnt <= '0;
      r_px <= '0; r_py <= '0; r_sph <= '0; r_en <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_px  <= pixel_start_x;
          r_py  <= pixel_y;
          r_sph <= sphere_i;
          r_en  <= sphere_en_i;
          r_job <= '0;
          r_k   <= '0;
          busy  <= 1'b1;
        end
        S_ISSUE: begin
          r_k   <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
          r_cnt <= '0;
        end
        S_DRAIN: r_cnt <= r_cnt + 4'd1;
        S_COMMIT: begin
          buf_o[r_job] <= r_found ? r_win : BG_COLOR;
          if (r_job == J_LAST) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            r_job <= r_job + 1'b1;
            r_px  <= r_px + 12'(N_WORKERS);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
